imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate extender for the decode stage.
- Decodes all RV32I immediate formats (I, S, B, U, J) from a full instruction word and sign-extends the result to XLEN.
- Carries a sideband tag with each result.
- Decouples producer and consumer with valid/ready handshakes and a 2-entry output buffer; in_ready depends only on registered state.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag passed through unchanged (e.g. rd index).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush; empties the buffer
- in_valid  input  1  instruction beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_instr  input  32  instruction word; bits [31:7] used
- in_immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, others illegal
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry
- out_imm  output  XLEN  extended immediate of head entry
- out_err  output  1  head entry had an illegal immsrc
- out_tag  output  TAG_W  tag of head entry

Behaviour:
- Reset, asynchronous on rst_n low:
  - count=0; rd_ptr=wr_ptr=0.
  - out_valid=0, out_imm=0, out_err=0, out_tag=0, in_ready=1.
  - Reset mid-transfer discards all held entries.
- Immediate formats, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
- Illegal immsrc (101, 110, 111): immediate = 0, err = 1. The entry is still buffered and delivered in order.
- Push occurs when in_valid && in_ready. The computed immediate, err and tag are written into the buffer entry at wr_ptr.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 at the earliest. There is no combinational path from in_* to out_*.
- Pop occurs when out_valid && out_ready; rd_ptr advances.
- Buffer: 2 entries with 1-bit pointers that wrap 1 -> 0.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_* are driven from the entry at rd_ptr.
  - When count = 0, out_imm, out_err and out_tag hold 0.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at count = 1.
  - At count = 2 a push cannot occur because in_ready = 0.
  - At count = 0 a pop cannot occur because out_valid = 0.
- Full (count = 2): in_ready = 0. It returns to 1 the cycle after the first pop.
- Empty (count = 0): out_valid = 0.
- Flush:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle completes as normal on the consumer side.
  - Flush has priority over push and pop.
- Producer rule: in_* must stay stable while in_valid=1 and in_ready=0. The bench asserts this; the DUT does not check it.

Decomposition:
- Shared package imm_pkg holds:
  - the immsrc_t enum (IMM_I=3'b000, IMM_S, IMM_B, IMM_U, IMM_J)
  - the constants XLEN_DEFAULT=32 and BUF_DEPTH=2
  - the function imm_decode(instr, immsrc), which returns {err, imm[63:0]}; the caller truncates to XLEN.
- One sub-module, imm_skid_buf: the 2-entry valid/ready buffer, parametrised on payload width (XLEN+1+TAG_W).
- The top module instantiates the decode function and imm_skid_buf.

Test Plan:
- I format, XLEN=32: instr 0xFFF00093, immsrc 000, tag 5'd1, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0, out_tag=1.
- S and B formats: 0xFE112E23 with immsrc 001 -> 0xFFFFFFFC; then 0xFE000CE3 with immsrc 010 -> 0xFFFFFFF8. Delivered in order, one per cycle, with in_ready held at 1.
- U and J formats, XLEN=64:
  - 0x800000B7 with immsrc 011 -> 0xFFFFFFFF80000000.
  - 0xFFDFF06F with immsrc 100 -> 0xFFFFFFFFFFFFFFFC.
  - Illegal immsrc 111 -> out_imm=0, out_err=1.
- Backpressure, XLEN=32:
  - out_ready=0; push 3 beats with tags 1, 2, 3 -> in_ready falls to 0 after 2 accepts.
  - Beat 3 is held stable.
  - Raise out_ready -> tags delivered 1, 2, 3 in order, and in_ready returns to 1 one cycle after the first pop.
- Flush: with 2 entries held, assert flush together with in_valid -> next cycle out_valid=0, count=0, in_ready=1. The flushed-cycle beat never appears on the output.
- Reset mid-operation: with 1 entry held, pulse rst_n low asynchronously mid-cycle -> out_valid=0 and out_imm=0 immediately. After release, the next push is delivered normally.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types, constants and the RV32I immediate decode function.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } immsrc_t;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned BUF_DEPTH    = 2;

  // Returns {err, imm[63:0]}; imm is sign-extended from instr[31], caller truncates.
  function automatic logic [64:0] imm_decode(input logic [31:0] instr,
                                             input logic [2:0]  immsrc);
    logic [63:0] imm;
    logic        err;
    logic        unused_lo;
    imm       = '0;
    err       = 1'b0;
    unused_lo = ^instr[6:0];
    case (immsrc_t'(immsrc))
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: err = 1'b1;
    endcase
    return {err, imm};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready buffer; ready and valid come from registered occupancy only.
module imm_skid_buf
  import imm_pkg::*;
#(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int unsigned DEPTH = BUF_DEPTH;
  localparam int unsigned CNT_W = 2;

  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             push, pop;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // Next occupancy and pointers; flush overrides any push or pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; a push in a flush cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Decode-stage immediate extender: decode, tag, and buffer behind valid/ready.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = XLEN + 1 + TAG_W;

  logic [64:0]   dec;
  logic [PW-1:0] push_data;
  logic [PW-1:0] pop_data;
  logic          unused_dec;

  // Decode on the way in so the buffer holds finished results.
  assign dec        = imm_decode(in_instr, in_immsrc);
  assign unused_dec = ^dec;
  assign push_data  = {dec[64], dec[XLEN-1:0], in_tag};

  imm_skid_buf #(
    .W(PW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign {out_err, out_imm, out_tag} = pop_data;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus, checked against a queue model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_immsrc;
  logic [4:0]  in_tag;

  logic        rdy32, rdy64, ov32, ov64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_err(err32), .out_tag(tag32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_err(err64), .out_tag(tag64)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] imm;
    logic [4:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] p_instr;
  logic [2:0]  p_src;
  logic [4:0]  p_tag;
  logic [31:0] hold_instr;

  // Immediate value computed arithmetically from field weights.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] src,
                                     input logic [4:0] tag);
    exp_t   e;
    longint sx;
    longint v;
    sx = $signed(ins);
    v  = 0;
    e.err = 1'b0;
    case (src)
      3'd0: v = sx >>> 20;
      3'd1: v = ((sx >>> 25) <<< 5) + ((sx >> 7) & 31);
      3'd2: v = ((sx >>> 31) <<< 12) + ((sx >> 7) & 1) * 2048
                + ((sx >> 25) & 63) * 32 + ((sx >> 8) & 15) * 2;
      3'd3: v = sx & ~longint'(4095);
      3'd4: v = ((sx >>> 31) <<< 20) + ((sx >> 12) & 255) * 4096
                + ((sx >> 20) & 1) * 2048 + ((sx >> 21) & 1023) * 2;
      default: e.err = 1'b1;
    endcase
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: compare outputs to the model head, then advance the model.
  task automatic cycle();
    exp_t h;
    logic exp_rdy, push, pop;
    @(negedge clk);
    exp_rdy = (q.size() < 2);
    h = (q.size() > 0) ? q[0] : '0;
    chk("in_ready32",  64'(rdy32), 64'(exp_rdy));
    chk("in_ready64",  64'(rdy64), 64'(exp_rdy));
    chk("out_valid32", 64'(ov32), 64'(q.size() != 0));
    chk("out_valid64", 64'(ov64), 64'(q.size() != 0));
    chk("out_imm32",   64'(imm32), 64'(h.imm[31:0]));
    chk("out_imm64",   imm64, h.imm);
    chk("out_err32",   64'(err32), 64'(h.err));
    chk("out_err64",   64'(err64), 64'(h.err));
    chk("out_tag32",   64'(tag32), 64'(h.tag));
    chk("out_tag64",   64'(tag64), 64'(h.tag));
    if (stall_prev)
      chk("producer_hold", 64'({in_valid, in_instr, in_immsrc, in_tag}),
          64'({1'b1, p_instr, p_src, p_tag}));
    push = in_valid && exp_rdy;
    pop  = out_ready && (q.size() > 0);
    stall_prev = in_valid && !exp_rdy && !flush;
    p_instr = in_instr;
    p_src   = in_immsrc;
    p_tag   = in_tag;
    if (flush) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(ref_model(in_instr, in_immsrc, in_tag));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_immsrc = '0; in_tag = '0;
    #12;
    chk("rst_valid", 64'(ov32), 64'd0);
    chk("rst_imm",   imm64, 64'd0);
    chk("rst_err",   64'(err32), 64'd0);
    chk("rst_tag",   64'(tag32), 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // I format
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_immsrc = 3'b000; in_tag = 5'd1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("i_valid", 64'(ov32), 64'd1);
    chk("i_imm",   64'(imm32), 64'hFFFF_FFFF);
    chk("i_err",   64'(err32), 64'd0);
    chk("i_tag",   64'(tag32), 64'd1);
    cycle();

    // S then B, back to back
    in_valid = 1'b1; in_instr = 32'hFE112E23; in_immsrc = 3'b001; in_tag = 5'd2;
    cycle();
    chk("s_imm", 64'(imm32), 64'hFFFF_FFFC);
    chk("s_ready", 64'(rdy32), 64'd1);
    in_instr = 32'hFE000CE3; in_immsrc = 3'b010; in_tag = 5'd3;
    cycle();
    in_valid = 1'b0;
    chk("b_imm", 64'(imm32), 64'hFFFF_FFF8);
    chk("b_tag", 64'(tag32), 64'd3);
    cycle();

    // U, J and illegal on the 64-bit instance
    in_valid = 1'b1; in_instr = 32'h800000B7; in_immsrc = 3'b011; in_tag = 5'd4;
    cycle();
    chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    in_instr = 32'hFFDFF06F; in_immsrc = 3'b100; in_tag = 5'd5;
    cycle();
    chk("j_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    in_instr = 32'h12345678; in_immsrc = 3'b111; in_tag = 5'd6;
    cycle();
    in_valid = 1'b0;
    chk("ill_imm64", imm64, 64'd0);
    chk("ill_err64", 64'(err64), 64'd1);
    cycle();

    // Backpressure: third beat held until space frees
    out_ready = 1'b0; in_valid = 1'b1; in_immsrc = 3'b000;
    in_instr = $urandom; in_tag = 5'd1; cycle();
    in_instr = $urandom; in_tag = 5'd2; cycle();
    hold_instr = $urandom; in_instr = hold_instr; in_tag = 5'd3;
    chk("bp_full", 64'(rdy32), 64'd0);
    cycle();
    cycle();
    out_ready = 1'b1;
    chk("bp_head1", 64'(tag32), 64'd1);
    cycle();
    chk("bp_ready_back", 64'(rdy32), 64'd1);
    chk("bp_head2", 64'(tag32), 64'd2);
    cycle();
    in_valid = 1'b0;
    chk("bp_head3", 64'(tag32), 64'd3);
    cycle();

    // Flush with two entries held and a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_immsrc = 3'b001;
    in_instr = $urandom; in_tag = 5'd7; cycle();
    in_instr = $urandom; in_tag = 5'd8; cycle();
    in_instr = $urandom; in_tag = 5'd9; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(ov32), 64'd0);
    chk("fl_ready", 64'(rdy32), 64'd1);
    cycle();

    // Flush with one entry: pop completes, accepted push is dropped
    out_ready = 1'b1; in_valid = 1'b1; in_immsrc = 3'b010;
    in_instr = $urandom; in_tag = 5'd10; cycle();
    in_instr = $urandom; in_tag = 5'd11; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_valid", 64'(ov32), 64'd0);
    cycle();

    // Asynchronous reset mid-cycle with one entry held
    out_ready = 1'b0; in_valid = 1'b1; in_immsrc = 3'b100;
    in_instr = 32'hFFDFF06F; in_tag = 5'd12; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov32), 64'd0);
    chk("arst_imm32", 64'(imm32), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_ready", 64'(rdy32), 64'd1);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; in_immsrc = 3'b000; in_instr = 32'hFFF00093; in_tag = 5'd13;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(ov32), 64'd1);
    chk("post_rst_tag",   64'(tag32), 64'd13);
    cycle();

    // Random traffic; stalled beats stay stable
    for (int i = 0; i < 400; i++) begin
      if (!stall_prev) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_instr  = $urandom;
        in_immsrc = 3'($urandom_range(0, 7));
        in_tag    = 5'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
